// File: rtl/periph_bus_master_pkg.sv
// Shared definitions for the peripheral bus master: register map offsets,
// UART_CON bit positions and the sequencing state encoding.
package periph_bus_master_pkg;

  // Byte offsets from the peripheral base address.
  localparam logic [31:0] OFF_TH     = 32'h00;
  localparam logic [31:0] OFF_TL     = 32'h04;
  localparam logic [31:0] OFF_TCON   = 32'h08;
  localparam logic [31:0] OFF_LED    = 32'h0C;
  localparam logic [31:0] OFF_SWITCH = 32'h10;
  localparam logic [31:0] OFF_DIGI   = 32'h14;
  localparam logic [31:0] OFF_TXD    = 32'h18;
  localparam logic [31:0] OFF_RXD    = 32'h1C;
  localparam logic [31:0] OFF_CON    = 32'h20;

  // UART_CON status bits.
  localparam int unsigned RX_FLAG_BIT = 3;
  localparam int unsigned TX_BUSY_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_POLL_RX,
    ST_READ_RXD,
    ST_POLL_TX,
    ST_WRITE_TXD
  } state_t;

  // Saturating increment for the 8-bit overrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Bus initiator for the memory-mapped peripheral space. Serves a one-shot
// command port and a UART echo engine (poll CON, read RXD, write TXD) over
// a single registered rd/wr/addr/wdata bus with combinational read data.
module periph_bus_master
  import periph_bus_master_pkg::*;
#(
  parameter int unsigned TX_GUARD    = 400,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        echo_en,
  output logic [15:0] echo_cnt,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned    GW         = $clog2(TX_GUARD + 1);
  localparam logic [GW-1:0]  GUARD_LOAD = GW'(TX_GUARD);

  localparam logic [31:0] ADDR_CON = PERIPH_BASE + OFF_CON;
  localparam logic [31:0] ADDR_RXD = PERIPH_BASE + OFF_RXD;
  localparam logic [31:0] ADDR_TXD = PERIPH_BASE + OFF_TXD;

  state_t        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [7:0]    echo_byte_q, echo_byte_d;

  // Next values of the registered bus and status outputs.
  logic        rd_d, wr_d;
  logic [31:0] addr_d, wdata_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic [15:0] echo_cnt_d;
  logic [7:0]  overrun_d;

  assign cmd_ready = (state_q == ST_IDLE);

  // Next-state and next-output logic; the strobe for a state is set up on the
  // transition into it so the bus outputs come straight from flops.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    guard_d     = (guard_q != '0) ? guard_q - 1'b1 : '0;
    echo_byte_d = echo_byte_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = addr;
    wdata_d     = wdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    echo_cnt_d  = echo_cnt;
    overrun_d   = overrun_cnt;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_CMD;
          rd_d    = ~cmd_wr;
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          if (cmd_wr) wdata_d = cmd_wdata;
        end else if (echo_en && guard_q == '0) begin
          state_d = ST_POLL_RX;
          rd_d    = 1'b1;
          addr_d  = ADDR_CON;
        end
      end

      ST_CMD: begin
        // The rd flop still tells us whether this was a read.
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd ? rdata : '0;
      end

      ST_POLL_RX: begin
        // No data: drop back to IDLE so a waiting command can slip in.
        if (rdata[RX_FLAG_BIT]) begin
          state_d = ST_READ_RXD;
          rd_d    = 1'b1;
          addr_d  = ADDR_RXD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ_RXD: begin
        echo_byte_d = rdata[7:0];
        state_d     = ST_POLL_TX;
        rd_d        = 1'b1;
        addr_d      = ADDR_CON;
      end

      ST_POLL_TX: begin
        // Each CON read clears the RX flag, so a flag seen here is a byte lost.
        if (rdata[RX_FLAG_BIT]) overrun_d = sat_inc8(overrun_cnt);
        if (!rdata[TX_BUSY_BIT]) begin
          state_d = ST_WRITE_TXD;
          wr_d    = 1'b1;
          addr_d  = ADDR_TXD;
          wdata_d = {24'b0, echo_byte_q};
        end else begin
          rd_d   = 1'b1;
          addr_d = ADDR_CON;
        end
      end

      ST_WRITE_TXD: begin
        state_d    = ST_IDLE;
        echo_cnt_d = echo_cnt + 16'd1;
        guard_d    = GUARD_LOAD;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, guard and output registers; reset kills any strobe in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      guard_q     <= '0;
      echo_byte_q <= '0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      echo_cnt    <= '0;
      overrun_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      guard_q     <= guard_d;
      echo_byte_q <= echo_byte_d;
      rd          <= rd_d;
      wr          <= wr_d;
      addr        <= addr_d;
      wdata       <= wdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      echo_cnt    <= echo_cnt_d;
      overrun_cnt <= overrun_d;
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master: a scripted peripheral bus model,
// a bus-event log, and a reference of expected transactions and counters.
module tb_periph_bus_master;
  import periph_bus_master_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int unsigned GUARD = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        echo_en = 1'b0;
  logic [15:0] echo_cnt;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  periph_bus_master #(.TX_GUARD(GUARD), .PERIPH_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .echo_en(echo_en), .echo_cnt(echo_cnt),
    .overrun_cnt(overrun_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Peripheral model: CON answers from a script, RXD from rxd_val, the rest is RAM.
  logic [31:0] bus_mem [0:15] = '{4: 32'h5A, default: 32'h0};
  logic [31:0] con_script [0:511];
  int          con_len = 0;
  int          con_idx = 0;
  logic [31:0] rxd_val = '0;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == BASE + OFF_CON)      rdata = (con_idx < con_len) ? con_script[con_idx] : 32'h0;
      else if (addr == BASE + OFF_RXD) rdata = rxd_val;
      else                             rdata = bus_mem[addr[5:2]];
    end
  end

  always @(posedge clk) begin
    if (rd && addr == BASE + OFF_CON) con_idx <= con_idx + 1;
    if (wr) bus_mem[addr[5:2]] <= wdata;
  end

  // Bus-event log sampled mid-cycle.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } bus_ev_t;

  bus_ev_t ev_q[$];
  int      cyc = 0;
  int      both_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd || wr) ev_q.push_back('{rd, wr, addr, wdata, cyc});
    if (rd && wr) both_hi <= both_hi + 1;
  end

  // Reference state.
  logic [31:0] ref_mem [0:15];
  int          exp_echo = 0;
  int          exp_overrun = 0;

  task automatic push_con(input logic [31:0] v);
    con_script[con_len] = v;
    con_len++;
  endtask

  task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rsp);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("cmd_strobe_rd", 32'(rd), 32'(!w));
    check("cmd_strobe_wr", 32'(wr), 32'(w));
    check("cmd_addr", addr, a);
    if (w) check("cmd_wdata", wdata, d);
    check("cmd_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("cmd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("cmd_rsp_rdata", rsp_rdata, exp_rsp);
    check("cmd_strobe_done", 32'({rd, wr}), 32'd0);
    @(negedge clk);
    check("cmd_rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_txd(input int limit, output int found_cyc);
    found_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (wr && addr == BASE + OFF_TXD) begin
        found_cyc = cyc;
        break;
      end
    end
    check("txd_seen", 32'(found_cyc >= 0), 32'd1);
  endtask

  // Expected echo: CON, RXD, (busy+1) CON polls, then TXD write, back to back.
  task automatic check_echo(input int idx, input logic [7:0] b, input int busy);
    int n;
    n = busy + 4;
    if (ev_q.size() < idx + n) begin
      check("echo_len", 32'(ev_q.size()), 32'(idx + n));
      return;
    end
    for (int k = 0; k < n; k++) begin
      logic [31:0] ea;
      logic        ew;
      ew = (k == n - 1);
      if (k == 1)   ea = BASE + OFF_RXD;
      else if (ew)  ea = BASE + OFF_TXD;
      else          ea = BASE + OFF_CON;
      check($sformatf("echo_ev%0d_rdwr", k), {30'b0, ev_q[idx+k].rd, ev_q[idx+k].wr},
            {30'b0, !ew, ew});
      check($sformatf("echo_ev%0d_addr", k), ev_q[idx+k].addr, ea);
      if (k > 0)
        check($sformatf("echo_ev%0d_gap", k), 32'(ev_q[idx+k].cyc - ev_q[idx+k-1].cyc), 32'd1);
    end
    check("echo_wdata", ev_q[idx+n-1].wdata, {24'b0, b});
  endtask

  task automatic account_echo(input logic [7:0] b, input int flagged);
    exp_echo++;
    exp_overrun = (exp_overrun + flagged > 255) ? 255 : exp_overrun + flagged;
    ref_mem[6] = {24'b0, b};
    check("echo_cnt", 32'(echo_cnt), 32'(exp_echo));
    check("overrun_cnt", 32'(overrun_cnt), 32'(exp_overrun));
  endtask

  // One echo: mode 0 uses the plain CON values, mode 1 randomises the
  // unrelated CON bits, RXD upper bits and the RX flag during TX polls.
  task automatic run_echo(input logic [7:0] b, input int busy, input bit mode);
    int          mark, fc, flagged;
    logic [31:0] r, v;
    flagged = 0;
    r = $urandom;
    push_con(mode ? ((r & ~32'h18) | 32'h08) : 32'h08);
    for (int j = 0; j < busy; j++) begin
      r = $urandom;
      v = mode ? ((r & ~32'h18) | 32'h10 | (32'($urandom_range(0, 1)) << 3)) : 32'h18;
      if (v[3]) flagged++;
      push_con(v);
    end
    r = $urandom;
    v = mode ? (r & ~32'h10) : 32'h00;
    if (v[3]) flagged++;
    push_con(v);
    r = $urandom;
    rxd_val = mode ? {r[31:8], b} : {24'b0, b};
    mark = ev_q.size();
    echo_en = 1'b1;
    wait_txd(2000 + busy, fc);
    echo_en = 1'b0;
    @(negedge clk);
    check_echo(mark, b, busy);
    account_echo(b, flagged);
  endtask

  initial begin
    int w1, w2, mark;
    logic [31:0] d;
    int idx;
    bit w;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_mem[4] = 32'h5A;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", 32'({rd, wr}), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_rsp", {31'b0, rsp_valid} | rsp_rdata, 32'h0);
    check("rst_cnts", {8'b0, echo_cnt, overrun_cnt}, 32'h0);

    // Directed commands.
    do_cmd(1'b1, BASE + OFF_LED, 32'hA5, 32'h0);
    ref_mem[3] = 32'hA5;
    do_cmd(1'b0, BASE + OFF_SWITCH, 32'h0, 32'h5A);

    // Basic echo, then TX busy for five polls.
    run_echo(8'h41, 0, 1'b0);
    run_echo(8'h77, 5, 1'b0);

    // Command wins over a pending echo; second byte honours the TX guard.
    repeat (GUARD + 20) @(negedge clk);
    push_con(32'h08);
    push_con(32'h00);
    rxd_val = 32'hC3;
    mark = ev_q.size();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = BASE + OFF_TH;
    echo_en = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_txd(100, w1);
    @(negedge clk);
    if (ev_q.size() > mark) begin
      check("prio_first_addr", ev_q[mark].addr, BASE + OFF_TH);
      check("prio_first_rd", 32'(ev_q[mark].rd), 32'd1);
    end else begin
      check("prio_events", 32'(ev_q.size()), 32'(mark + 1));
    end
    check_echo(mark + 1, 8'hC3, 0);
    account_echo(8'hC3, 0);
    repeat (9) @(negedge clk);
    push_con(32'h08);
    push_con(32'h00);
    rxd_val = 32'h99;
    mark = ev_q.size();
    wait_txd(1000, w2);
    @(negedge clk);
    echo_en = 1'b0;
    check("txd_spacing", 32'((w2 - w1) >= int'(GUARD + 1)), 32'd1);
    check_echo(mark, 8'h99, 0);
    account_echo(8'h99, 0);

    // Random commands against the reference memory.
    for (int i = 0; i < 20; i++) begin
      w   = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 6);
      d   = $urandom;
      if (w) begin
        do_cmd(1'b1, BASE + 32'(idx * 4), d, 32'h0);
        ref_mem[idx] = d;
      end else begin
        do_cmd(1'b0, BASE + 32'(idx * 4), d, ref_mem[idx]);
      end
    end

    // Random echoes, then a long busy wait that saturates the overrun counter.
    for (int i = 0; i < 3; i++) run_echo(8'($urandom), $urandom_range(0, 4), 1'b1);
    run_echo(8'h5C, 260, 1'b0);
    do_cmd(1'b0, BASE + OFF_TXD, 32'h0, ref_mem[6]);

    // Reset in the middle of a command write.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = BASE + OFF_LED; cmd_wdata = 32'h3C;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("midrst_wr_before", 32'(wr), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_wr_drop", 32'({rd, wr}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_addr", addr, 32'h0);
    check("post_rst_wdata", wdata, 32'h0);
    check("post_rst_cnts", {8'b0, echo_cnt, overrun_cnt}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_quiet", {29'b0, rd, wr, rsp_valid} | rsp_rdata, 32'h0);
      @(negedge clk);
    end

    check("rd_wr_exclusive", 32'(both_hi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

Bus initiator for the memory-mapped peripheral space at 0x4000_0000. It drives the same `rd`/`wr`/`addr`/`wdata`/`rdata` bus the CPU data port uses to reach the timer, LED/switch/digit and UART registers. It serves two request sources: a single-transaction command port for test/debug, and a built-in UART echo engine that polls UART_CON, reads UART_RXD and writes the byte back to UART_TXD.

## Interface
Parameters:
- `TX_GUARD`, 400: minimum cycles between consecutive UART_TXD writes. Must exceed the peripheral's TX_EN stretch of 325 cycles.
- `PERIPH_BASE`, 32'h4000_0000: base address of the register map.

Ports:
- `clk`  in  1: single clock. All logic is posedge.
- `reset`  in  1: asynchronous, active-low.
- `rd`  out  1: bus read strobe, one cycle per read.
- `wr`  out  1: bus write strobe, one cycle per write. Never high together with `rd`.
- `addr`  out  32: bus address.
- `wdata`  out  32: bus write data.
- `rdata`  in  32: bus read data. Combinational from `rd`/`addr`, valid in the same cycle.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: command accepted when high together with `cmd_valid`.
- `cmd_wr`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  32: command address.
- `cmd_wdata`  in  32: command write data.
- `rsp_valid`  out  1: one-cycle pulse when a command completes.
- `rsp_rdata`  out  32: read data for a read; 0 for a write.
- `echo_en`  in  1: enables the UART echo engine.
- `echo_cnt`  out  16: bytes echoed. Wraps.
- `overrun_cnt`  out  8: RX flags lost while waiting on TX. Saturates at 255.

## Operation
- States: IDLE, CMD, POLL_RX, READ_RXD, POLL_TX, WRITE_TXD.
- `cmd_ready` = (state == IDLE).
- IDLE:
  - `cmd_valid` → CMD. Command has priority over echo.
  - Otherwise, `echo_en` and guard counter == 0 → POLL_RX.
- CMD: drive `rd` or `wr` with `cmd_addr`/`cmd_wdata` for one cycle; capture `rdata` at the edge. Next cycle `rsp_valid`=1 and state is IDLE.
- POLL_RX: read UART_CON (base+0x20).
  - `rdata[3]`=1 → READ_RXD.
  - Otherwise → IDLE, so commands can interleave between polls.
- READ_RXD: read base+0x1C; latch `rdata[7:0]` into the echo byte register → POLL_TX.
- POLL_TX: read UART_CON.
  - `rdata[4]`=0 (TX idle) → WRITE_TXD; otherwise stay.
  - The peripheral clears CON[3:2] on every CON read. If `rdata[3]`=1 in POLL_TX, increment `overrun_cnt`.
- WRITE_TXD: write `{24'b0, byte}` to base+0x18; increment `echo_cnt`; load guard counter with TX_GUARD → IDLE.
- Guard counter decrements to 0 in every state.
- `echo_en` falling mid-sequence: finish through WRITE_TXD so the byte is not dropped, then stay in IDLE.
- Bus outputs are registered. `addr`/`wdata` hold their last value when `rd`=`wr`=0.

## Timing
- Reset values: `rd`=0, `wr`=0, `addr`=0, `wdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `echo_cnt`=0, `overrun_cnt`=0, guard=0, state IDLE (so `cmd_ready`=1).
- Reset asserted mid-transaction drops `rd`/`wr` immediately, with no completion response.
- Command latency: accept at edge N; strobe during cycle N+1; `rsp_valid` during N+2.
- Echo best case, from IDLE with data pending: POLL_RX, READ_RXD, POLL_TX, WRITE_TXD. That is 4 strobe cycles; the `wr` strobe is the 4th cycle after leaving IDLE.
- Consecutive TXD writes are at least TX_GUARD+1 cycles apart.
- Counters use fixed widths: `echo_cnt` wraps 0xFFFF→0; `overrun_cnt` holds at 0xFF.

## Structure
- Shared package holds:
  - Register offsets: TH 0x00, TL 0x04, TCON 0x08, LED 0x0C, SWITCH 0x10, DIGI 0x14, TXD 0x18, RXD 0x1C, CON 0x20.
  - UART_CON bit indices: RX_FLAG=3, TX_BUSY=4.
  - The FSM state enum.
- Single module; no sub-module is natural.

## Test plan
- Reset mid-CMD with `wr`=1 → `wr` drops at once; after release `cmd_ready`=1 and all outputs are 0.
- Command write 0x4000_000C / 0xA5 → one cycle of `wr`=1, `addr`=0x4000_000C, `wdata`=0xA5; next cycle `rsp_valid`=1, `rsp_rdata`=0.
- Command read 0x4000_0010, bus model returns 0x5A → one `rd` cycle; `rsp_valid`=1, `rsp_rdata`=0x5A.
- Echo: CON returns 0x08, RXD returns 0x41, then CON returns 0x00 → strobes are rd 0x20, rd 0x1C, rd 0x20, wr 0x18 with `wdata`=0x41; `echo_cnt`=1.
- TX busy: CON returns 0x18 for 5 polls, then 0x00 → no `wr` until bit 4 clears; `overrun_cnt`=5.
- `cmd_valid` and a pending echo in IDLE together → command is served first. A second RX byte arriving 10 cycles after the first TXD write is written ≥401 cycles after it.
